regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader.sv | 86 ++++++++
 tb/tb_regfile_dump_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register range through one read port and streams (addr, data) words
module regfile_dump_reader #(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] first_addr,
  input  logic [W-1:0] last_addr,
  output logic [W-1:0] rf_r_addr,
  input  logic [B-1:0] rf_r_data,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [W-1:0] dump_addr,
  output logic [B-1:0] dump_data,
  output logic         dump_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_cur;
  logic [W-1:0] r_last;
  logic [W-1:0] r_dump_addr;
  logic [B-1:0] r_dump_data;
  logic         r_dump_last;
  logic         w_xfer;

  // abort wins over a same-cycle handshake, so that word is never counted
  assign w_xfer = (r_state == S_SEND) && dump_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_READ;
      S_READ: w_next = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (abort)       w_next = S_IDLE;
        else if (w_xfer) w_next = r_dump_last ? S_DONE : S_READ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_cur doubles as the read address; it only moves on start or a non-final transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur       <= '0;
      r_last      <= '0;
      r_dump_addr <= '0;
      r_dump_data <= '0;
      r_dump_last <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_cur  <= first_addr;
        r_last <= last_addr;
      end
      if (r_state == S_READ && !abort) begin
        r_dump_addr <= r_cur;
        r_dump_data <= rf_r_data;
        r_dump_last <= (r_cur == r_last);
      end
      if (w_xfer && !r_dump_last) r_cur <= r_cur + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign rf_r_addr  = r_cur;
  assign dump_valid = (r_state == S_SEND);
  assign dump_addr  = r_dump_addr;
  assign dump_data  = r_dump_data;
  assign dump_last  = r_dump_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed table-driven bench for regfile_dump_reader
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_r_addr;
  logic [31:0] rf_r_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         n;
    bit         poke;
    bit         sa;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  assign rf_r_data = rf[rf_r_addr];

  regfile_dump_reader #(.B(32), .W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // f/l: range, n: expected words, poke: pulse a conflicting start mid-dump, sa: abort with start
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int n,
                          input bit poke, input bit sa);
    int k, cyc, first_v, dones;
    logic [4:0] ea;
    @(negedge clk);
    start = 1'b1; abort = sa; first_addr = f; last_addr = l; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_in_read", dump_valid, 0);
    chk("rd_addr_first", rf_r_addr, f);
    k = 0; cyc = 1; first_v = -1; dones = 0;
    while (dones == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (dump_valid) begin
        if (first_v < 0) first_v = cyc;
        ea = f + 5'(k);
        chk("word_addr", dump_addr, ea);
        chk("word_data", dump_data, init_val(int'(ea)));
        chk("word_last", dump_last, (k == n - 1));
        k++;
        if (poke && k == 1) begin
          start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
        end
      end
      if (done) dones++;
    end
    chk("valid_latency", first_v, 2);
    chk("word_count", k, n);
    chk("done_seen", dones, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, rf_r_addr, 0);
    chk({tag, "_valid"}, dump_valid, 0);
    chk({tag, "_addr"}, dump_addr, 0);
    chk({tag, "_data"}, dump_data, 0);
    chk({tag, "_last"}, dump_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int cyc, nx, dn, vv;
    for (int i = 0; i < 32; i++) rf[i] = init_val(i);
    vecs[0] = '{f: 5'd3,  l: 5'd5,  n: 3,  poke: 1'b0, sa: 1'b0};
    vecs[1] = '{f: 5'd30, l: 5'd1,  n: 4,  poke: 1'b0, sa: 1'b0};
    vecs[2] = '{f: 5'd0,  l: 5'd31, n: 32, poke: 1'b0, sa: 1'b0};
    vecs[3] = '{f: 5'd7,  l: 5'd7,  n: 1,  poke: 1'b0, sa: 1'b0};
    vecs[4] = '{f: 5'd31, l: 5'd0,  n: 2,  poke: 1'b0, sa: 1'b0};
    vecs[5] = '{f: 5'd12, l: 5'd13, n: 2,  poke: 1'b1, sa: 1'b0};
    vecs[6] = '{f: 5'd20, l: 5'd22, n: 3,  poke: 1'b0, sa: 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++)
      run_dump(vecs[v].f, vecs[v].l, vecs[v].n, vecs[v].poke, vecs[v].sa);

    // backpressure on word 4 while the register file rewrites entry 4
    @(negedge clk);
    start = 1'b1; first_addr = 5'd3; last_addr = 5'd5; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(dump_valid && dump_addr == 5'd4) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_reach", (cyc < 50), 1);
    dump_ready = 1'b0;
    rf[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", dump_valid, 1);
      chk("bp_addr_hold", dump_addr, 4);
      chk("bp_data_hold", dump_data, 32'hC0DE_0004);
      chk("bp_last_hold", dump_last, 0);
    end
    dump_ready = 1'b1;
    @(negedge clk);
    chk("bp_one_xfer", dump_valid, 0);
    chk("bp_next_rd", rf_r_addr, 5);
    @(negedge clk);
    chk("bp_word5_addr", dump_addr, 5);
    chk("bp_word5_last", dump_last, 1);
    @(negedge clk);
    chk("bp_done", done, 1);
    rf[4] = init_val(4);

    // abort in SEND with ready high on the same cycle
    @(negedge clk);
    start = 1'b1; first_addr = 5'd10; last_addr = 5'd20; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; nx = 0;
    while (!(dump_valid && dump_addr == 5'd11) && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (dump_valid && dump_addr != 5'd11) nx++;
    end
    chk("abort_reach", (cyc < 50), 1);
    chk("abort_prior_xfers", nx, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", dump_valid, 0);
    chk("abort_busy", busy, 0);
    dn = 0; vv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (dump_valid) vv++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_valid", vv, 0);

    // asynchronous reset in the middle of a dump
    @(negedge clk);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    chk_reset_vals("midreset_hold");
    rst_n = 1'b1;
    run_dump(5'd0, 5'd0, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
